dest_reg_pipe: RTL and testbench
================================

// Module: dest_reg_pipe
// PURPOSE
//  Parametrised successor to the 2:1 write-register select. Picks the destination register (rt, rd,
//  link register or none) and carries it, with a write-valid bit, through DEPTH pipeline stages
//  (EX..WB) under stall/flush control. Also compares two source specifiers against every in-flight
//  destination and reports the youngest match for the forwarding and hazard units.
// PARAMETERS
//  WIDTH    5   register-specifier width
//  DEPTH    3   pipeline stages held (stage 0 = EX, DEPTH-1 = WB); legal range 2..8
//  LINK_REG 31  specifier forced for jal/jalr link writes
// PORTS
//  Clk        in   1               clock; all state updates on rising edge
//  Rst        in   1               synchronous, active-low reset
//  Stall      in   1               hold stage 0 and inject a bubble into stage 1
//  Flush      in   1               discard the input and clear stage 0
//  InValid    in   1               instruction at input is real (not a bubble)
//  RegWriteIn in   1               instruction writes the register file
//  DstSel     in   2               0=rt, 1=rd, 2=LINK_REG, 3=no destination
//  RtIn       in   WIDTH           rt field
//  RdIn       in   WIDTH           rd field
//  SrcA       in   WIDTH           rs of the consuming instruction
//  SrcB       in   WIDTH           rt of the consuming instruction
//  StageDst   out  DEPTH*WIDTH     flattened destination per stage; stage i at [i*WIDTH +: WIDTH]
//  StageWr    out  DEPTH           write-valid per stage
//  WbDst      out  WIDTH           = stage DEPTH-1 destination
//  WbWrite    out  1               = StageWr[DEPTH-1]
//  FwdSelA    out  clog2(DEPTH+1)  0 = no match; k = youngest matching stage is k-1
//  FwdSelB    out  clog2(DEPTH+1)  same for SrcB
// BEHAVIOUR
//  - Input decode (combinational):
//    - dst = RtIn / RdIn / LINK_REG / 0 for DstSel 0/1/2/3.
//    - wr = InValid & RegWriteIn & (DstSel!=3) & (dst!=0).
//    - A write to register 0 is never a write.
//  - Each stage holds {dst, wr}. A bubble is dst=0, wr=0.
//  - Reset (Rst==0 at an edge): every stage becomes a bubble. All outputs are 0 from the next cycle.
//    Reset overrides Stall and Flush and can be applied mid-stream.
//  - Normal edge (Stall=0, Flush=0):
//    - stage0 <= decoded input.
//    - stage i <= stage i-1 for i = 1..DEPTH-1.
//    - The old stage DEPTH-1 retires.
//  - Stall=1, Flush=0:
//    - stage0 holds.
//    - stage1 <= bubble.
//    - stages 2..DEPTH-1 advance normally.
//  - Flush=1 (Stall either value):
//    - stage0 <= bubble and the input is dropped.
//    - stages 1..DEPTH-1 advance normally, so stage1 takes the old stage0.
//    - Flush has priority over Stall.
//  - Latency: an input accepted at edge n appears on WbDst/WbWrite after edge n+DEPTH-1, i.e.
//    DEPTH edges after entering stage 0, counting the capture edge. Each Stall cycle while it sits
//    in stage 0 adds one cycle.
//  - Match logic (combinational, from registered state only):
//    - hitA[i] = StageWr[i] & (StageDst_i == SrcA).
//    - FwdSelA = (lowest i with hitA[i]) + 1, or 0 if there is no hit. The lowest i is the youngest
//      stage, which wins.
//    - SrcA==0 never hits, because wr is never set for register 0.
//    - FwdSelB is defined identically using SrcB.
//  - No output is left undriven for any DstSel value. DstSel==3 is fully defined, with no latch.
//  - All outputs are registered state except FwdSelA/B, WbDst and WbWrite, which are direct taps.
// TESTING
//  1. Reset, DEPTH=3: hold Rst=0 for 2 cycles -> StageWr=0, StageDst=0, FwdSelA=FwdSelB=0.
//  2. Feed three instructions on consecutive cycles, all RegWriteIn=1, Stall=0, Flush=0, then
//     bubbles:
//     - Inputs: (DstSel=0, Rt=8), (DstSel=1, Rd=9), (DstSel=2).
//     - Required: WbDst = 8, 9, 31 with WbWrite=1 on the 3rd, 4th and 5th edges after the first
//       capture.
//  3. Suppressed writes: DstSel=3 with Rt=5 -> WbWrite=0. DstSel=1 with Rd=0 -> WbWrite=0.
//     Neither ever matches SrcA=0 or SrcA=5.
//  4. Stall with Rd=12 in stage 0: one Stall cycle -> stage1 is a bubble and stage 0 still holds
//     12. The next edge moves 12 to stage 1. WbDst=12 arrives one cycle later than in the
//     unstalled case.
//  5. Flush with Stall=1 on the same edge, stage0 holding Rd=7, input Rd=4: stage0 becomes a
//     bubble, stage1=7, and 4 never appears at WB.
//  6. Forwarding priority: stages hold dst 10/10/10, all wr=1, SrcA=10 -> FwdSelA=1.
//     - Clear stage 0 (flush) -> FwdSelA=2.
//     - With SrcB=11 -> FwdSelB=0.
//     - Assert Rst mid-sequence -> FwdSelA=0 on the next cycle.

Source files
------------

// File: rtl/dest_reg_pipe.sv
// Destination-register select and DEPTH-stage tracking pipe (EX..WB).
// Also reports the youngest in-flight writer of each source operand for forwarding/hazard logic.
module dest_reg_pipe #(
    parameter int WIDTH    = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31,
    localparam int SELW    = $clog2(DEPTH + 1)
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Stall,
    input  logic                   Flush,
    input  logic                   InValid,
    input  logic                   RegWriteIn,
    input  logic [1:0]             DstSel,
    input  logic [WIDTH-1:0]       RtIn,
    input  logic [WIDTH-1:0]       RdIn,
    input  logic [WIDTH-1:0]       SrcA,
    input  logic [WIDTH-1:0]       SrcB,
    output logic [DEPTH*WIDTH-1:0] StageDst,
    output logic [DEPTH-1:0]       StageWr,
    output logic [WIDTH-1:0]       WbDst,
    output logic                   WbWrite,
    output logic [SELW-1:0]        FwdSelA,
    output logic [SELW-1:0]        FwdSelB
);

    localparam logic [WIDTH-1:0] LINK = WIDTH'(LINK_REG);

    logic [WIDTH-1:0] in_dst;
    logic             in_wr;

    logic [WIDTH-1:0] dst_q [DEPTH];
    logic [DEPTH-1:0] wr_q;
    logic [WIDTH-1:0] dst_d [DEPTH];
    logic [DEPTH-1:0] wr_d;

    logic             hold_s0;

    // Input decode; register 0 is a sink, so a write to it is never flagged.
    always_comb begin
        in_dst = '0;
        unique case (DstSel)
            2'd0:    in_dst = RtIn;
            2'd1:    in_dst = RdIn;
            2'd2:    in_dst = LINK;
            default: in_dst = '0;
        endcase
        in_wr = InValid & RegWriteIn & (DstSel != 2'd3) & (in_dst != '0);
    end

    assign hold_s0 = Stall & ~Flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            dst_d[i] = dst_q[i];
        end
        wr_d = wr_q;

        // Stage 0: flush beats stall; a stall simply keeps the current occupant.
        if (Flush) begin
            dst_d[0] = '0;
            wr_d[0]  = 1'b0;
        end else if (!Stall) begin
            dst_d[0] = in_dst;
            wr_d[0]  = in_wr;
        end

        for (int i = 1; i < DEPTH; i++) begin
            dst_d[i] = dst_q[i-1];
            wr_d[i]  = wr_q[i-1];
        end

        // While stage 0 is held, the slot behind it must be a bubble, not a duplicate.
        if (hold_s0) begin
            dst_d[1] = '0;
            wr_d[1]  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i] <= '0;
            end
            wr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i] <= dst_d[i];
            end
            wr_q <= wr_d;
        end
    end

    always_comb begin
        StageDst = '0;
        for (int i = 0; i < DEPTH; i++) begin
            StageDst[i*WIDTH +: WIDTH] = dst_q[i];
        end
    end

    assign StageWr = wr_q;
    assign WbDst   = dst_q[DEPTH-1];
    assign WbWrite = wr_q[DEPTH-1];

    // Scan oldest to youngest so the youngest hit overwrites and wins.
    always_comb begin
        FwdSelA = '0;
        FwdSelB = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (wr_q[i] && (dst_q[i] == SrcA)) begin
                FwdSelA = SELW'(i + 1);
            end
            if (wr_q[i] && (dst_q[i] == SrcB)) begin
                FwdSelB = SELW'(i + 1);
            end
        end
    end

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed bench for dest_reg_pipe (DEPTH=3): expected WB values are queued per edge
// and checked by an independent monitor; stage and forwarding values are checked inline.
module tb_dest_reg_pipe;

    localparam int WIDTH = 5;
    localparam int DEPTH = 3;
    localparam int SELW  = $clog2(DEPTH + 1);

    logic                   clk;
    logic                   rst;
    logic                   stall;
    logic                   flush;
    logic                   in_valid;
    logic                   reg_write;
    logic [1:0]             dst_sel;
    logic [WIDTH-1:0]       rt_in;
    logic [WIDTH-1:0]       rd_in;
    logic [WIDTH-1:0]       src_a;
    logic [WIDTH-1:0]       src_b;
    logic [DEPTH*WIDTH-1:0] stage_dst;
    logic [DEPTH-1:0]       stage_wr;
    logic [WIDTH-1:0]       wb_dst;
    logic                   wb_write;
    logic [SELW-1:0]        fwd_sel_a;
    logic [SELW-1:0]        fwd_sel_b;

    logic [WIDTH:0] exp_q[$];
    string          tag_q[$];

    int checks;
    int failures;

    dest_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LINK_REG(31)) dut (
        .Clk(clk), .Rst(rst), .Stall(stall), .Flush(flush),
        .InValid(in_valid), .RegWriteIn(reg_write), .DstSel(dst_sel),
        .RtIn(rt_in), .RdIn(rd_in), .SrcA(src_a), .SrcB(src_b),
        .StageDst(stage_dst), .StageWr(stage_wr), .WbDst(wb_dst), .WbWrite(wb_write),
        .FwdSelA(fwd_sel_a), .FwdSelB(fwd_sel_b)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: apply inputs, take one edge, queue the hand-computed WB value for that edge.
    task automatic step(input logic r, input logic st, input logic fl, input logic v,
                        input logic rw, input logic [1:0] sel, input logic [WIDTH-1:0] rt,
                        input logic [WIDTH-1:0] rd, input logic [WIDTH-1:0] e_dst,
                        input logic e_wr, input string tag);
        rst       = r;
        stall     = st;
        flush     = fl;
        in_valid  = v;
        reg_write = rw;
        dst_sel   = sel;
        rt_in     = rt;
        rd_in     = rd;
        @(posedge clk);
        #1;
        exp_q.push_back({e_wr, e_dst});
        tag_q.push_back(tag);
    endtask

    task automatic bubble(input logic [WIDTH-1:0] e_dst, input logic e_wr, input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, '0, '0, e_dst, e_wr, tag);
    endtask

    task automatic set_src(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        src_a = a;
        src_b = b;
        #1;
    endtask

    // Scoreboard monitor: one queued WB expectation per edge, compared mid-cycle.
    initial begin
        logic [WIDTH:0] exp_v;
        string          tag;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                tag   = tag_q.pop_front();
                chk(tag, {26'd0, wb_write, wb_dst}, {26'd0, exp_v});
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        reg_write = 1'b0;
        dst_sel   = 2'd3;
        rt_in     = '0;
        rd_in     = '0;
        src_a     = '0;
        src_b     = '0;

        // 1. Reset
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 5'd3, 5'd3, 5'd0, 1'b0, "rst_wb0");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 5'd3, 5'd3, 5'd0, 1'b0, "rst_wb1");
        set_src(5'd0, 5'd3);
        chk("rst_stage_wr", 32'(stage_wr), 32'd0);
        chk("rst_stage_dst", 32'(stage_dst), 32'd0);
        chk("rst_fwd_a", 32'(fwd_sel_a), 32'd0);
        chk("rst_fwd_b", 32'(fwd_sel_b), 32'd0);

        // 2. rt / rd / link through to WB
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 5'd8, 5'd1, 5'd0, 1'b0, "seq_e1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 5'd2, 5'd9, 5'd0, 1'b0, "seq_e2");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 5'd2, 5'd3, 5'd8, 1'b1, "seq_wb8");
        set_src(5'd8, 5'd9);
        chk("seq_stage_dst", 32'(stage_dst), 32'({5'd8, 5'd9, 5'd31}));
        chk("seq_fwd_a_8", 32'(fwd_sel_a), 32'd3);
        chk("seq_fwd_b_9", 32'(fwd_sel_b), 32'd2);
        set_src(5'd31, 5'd0);
        chk("seq_fwd_a_31", 32'(fwd_sel_a), 32'd1);
        chk("seq_fwd_b_0", 32'(fwd_sel_b), 32'd0);
        bubble(5'd9, 1'b1, "seq_wb9");
        bubble(5'd31, 1'b1, "seq_wb31");
        bubble(5'd0, 1'b0, "seq_drain");

        // 3. Suppressed writes
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 5'd5, 5'd6, 5'd0, 1'b0, "sup_e1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 5'd5, 5'd0, 5'd0, 1'b0, "sup_e2");
        set_src(5'd5, 5'd0);
        chk("sup_stage_wr", 32'(stage_wr), 32'd0);
        chk("sup_fwd_a_5", 32'(fwd_sel_a), 32'd0);
        chk("sup_fwd_b_0", 32'(fwd_sel_b), 32'd0);
        bubble(5'd0, 1'b0, "sup_wb_dstsel3");
        bubble(5'd0, 1'b0, "sup_wb_rd0");

        // 4. Stall with rd=12 in stage 0
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 5'd0, 5'd12, 5'd0, 1'b0, "stl_e1");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 5'd0, 5'd20, 5'd0, 1'b0, "stl_e2");
        chk("stl_s0_dst", 32'(stage_dst[WIDTH-1:0]), 32'd12);
        chk("stl_stage_wr", 32'(stage_wr), 32'b001);
        chk("stl_s1_dst", 32'(stage_dst[2*WIDTH-1:WIDTH]), 32'd0);
        bubble(5'd0, 1'b0, "stl_e3");
        chk("stl_s1_after", 32'(stage_dst[2*WIDTH-1:WIDTH]), 32'd12);
        bubble(5'd12, 1'b1, "stl_wb12_late");
        bubble(5'd0, 1'b0, "stl_drain");

        // 5. Flush with stall on the same edge
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 5'd0, 5'd7, 5'd0, 1'b0, "fl_e1");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 5'd0, 5'd4, 5'd0, 1'b0, "fl_e2");
        chk("fl_stage_wr", 32'(stage_wr), 32'b010);
        chk("fl_stage_dst", 32'(stage_dst), 32'({5'd0, 5'd7, 5'd0}));
        bubble(5'd7, 1'b1, "fl_wb7");
        bubble(5'd0, 1'b0, "fl_no4_a");
        bubble(5'd0, 1'b0, "fl_no4_b");

        // 6. Forwarding priority and mid-stream reset
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 5'd0, 5'd10, 5'd0, 1'b0, "fw_e1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 5'd0, 5'd10, 5'd0, 1'b0, "fw_e2");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 5'd0, 5'd10, 5'd10, 1'b1, "fw_wb10");
        set_src(5'd10, 5'd11);
        chk("fw_stage_wr", 32'(stage_wr), 32'b111);
        chk("fw_fwd_a_full", 32'(fwd_sel_a), 32'd1);
        chk("fw_fwd_b_11", 32'(fwd_sel_b), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 5'd0, 5'd10, 5'd10, 1'b1, "fw_flush_wb10");
        chk("fw_fwd_a_flushed", 32'(fwd_sel_a), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 5'd0, 5'd10, 5'd0, 1'b0, "fw_rst_wb");
        chk("fw_fwd_a_rst", 32'(fwd_sel_a), 32'd0);
        chk("fw_stage_wr_rst", 32'(stage_wr), 32'd0);
        bubble(5'd0, 1'b0, "fw_after_rst");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
